// File: rtl/z16_pkg.sv
// Shared Z16 definitions: register file geometry and the dumper FSM encoding.
package z16_pkg;

    localparam int unsigned Z16_DATA_WIDTH     = 16;
    localparam int unsigned Z16_REG_ADDR_WIDTH = 4;
    localparam int unsigned Z16_NUM_REGS       = 16;

    // Register-file dumper states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } z16_dump_state_e;

endpackage : z16_pkg

// File: rtl/z16_regfile_dumper.sv
// Debug read-out engine for the Z16 register file.
// Walks an inclusive, wrapping register-address range on the rs1 read port
// and streams each value with its address over a valid/ready interface.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 one-cycle start request (honoured only when idle)
//   i_first_addr/last_addr  inclusive range, latched on an accepted start
//   i_abort                 cancels an in-progress dump, no done pulse
//   o_rf_addr / i_rf_data   regfile rs1 read port (data is combinational)
//   o_valid/i_ready         stream handshake
//   o_data/o_addr/o_last    stream payload; o_last is combinational
//   o_busy                  high while not idle (owns rs1 address)
//   o_done                  one-cycle pulse after the final word is accepted
module z16_regfile_dumper
    import z16_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = Z16_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = Z16_REG_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_first_addr,
    input  logic [ADDR_WIDTH-1:0] i_last_addr,
    input  logic                  i_abort,
    output logic [ADDR_WIDTH-1:0] o_rf_addr,
    input  logic [DATA_WIDTH-1:0] i_rf_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done
);

    z16_dump_state_e       state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] end_ptr_q, end_ptr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  at_end;
    logic                  handshake;

    assign at_end    = (addr_q == end_ptr_q);
    assign handshake = valid_q & i_ready;

    // State and pointer registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            end_ptr_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            end_ptr_q <= end_ptr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        end_ptr_d = end_ptr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Start wins over a simultaneous abort here
                if (i_start) begin
                    rd_ptr_d  = i_first_addr;
                    end_ptr_d = i_last_addr;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                if (i_abort) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    data_d   = i_rf_data;
                    addr_d   = rd_ptr_q;
                    valid_d  = 1'b1;
                    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
                    state_d  = SEND;
                end
            end
            SEND: begin
                // Abort drops the in-flight word even on a handshake
                if (i_abort) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (handshake) begin
                    if (at_end) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Back-to-back capture keeps one word per cycle
                        data_d   = i_rf_data;
                        addr_d   = rd_ptr_q;
                        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign o_rf_addr = rd_ptr_q;
    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_addr    = addr_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_last    = valid_q & at_end;

endmodule : z16_regfile_dumper

// File: doc/z16_regfile_dumper.md
Name: z16_regfile_dumper

Overview:
- Debug read-out engine for the Z16 register file. It is the reader on the regfile's rs1 read port, the counterpart to the core-side writer on the rd write port.
- On a start pulse it walks an inclusive register-address range, one register per read, with wrap-around.
- Each register value goes out on a valid/ready stream with its address. The stream feeds the debug UART/trace path.
- Sits beside the core. While o_busy is high, a mux gives this block ownership of the rs1 address.

Parameters:
- DATA_WIDTH, 16, register width.
- ADDR_WIDTH, 4, register address width (16 registers).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_start  input  1  one-cycle start request; sampled only in IDLE.
- i_first_addr  input  ADDR_WIDTH  first register of the range; latched on accepted start.
- i_last_addr  input  ADDR_WIDTH  last register of the range, inclusive; latched on accepted start.
- i_abort  input  1  cancels an in-progress dump.
- o_rf_addr  output  ADDR_WIDTH  drives the regfile rs1 read address.
- i_rf_data  input  DATA_WIDTH  regfile rs1 read data; combinational from o_rf_addr in the same cycle.
- o_valid  output  1  stream word valid.
- i_ready  input  1  stream consumer ready.
- o_data  output  DATA_WIDTH  register value.
- o_addr  output  ADDR_WIDTH  register address of o_data.
- o_last  output  1  high with o_valid on the final word of the range.
- o_busy  output  1  high in any state other than IDLE.
- o_done  output  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset: state=IDLE. o_valid, o_busy, o_done, o_last = 0. o_data, o_addr, o_rf_addr = 0. Reset has priority over i_abort and i_start.
- Internal registers:
  - rd_ptr: next address to read. o_rf_addr = rd_ptr at all times.
  - end_ptr: last address of the range.
- State IDLE:
  - i_start=1 latches rd_ptr=i_first_addr and end_ptr=i_last_addr, then moves to FETCH.
  - Otherwise IDLE holds.
- State FETCH (exactly one cycle):
  - o_data<=i_rf_data, o_addr<=rd_ptr, o_valid<=1, rd_ptr<=rd_ptr+1 (mod 2^ADDR_WIDTH).
  - Next state is SEND.
- State SEND:
  - o_data, o_addr and o_valid hold stable while i_ready=0.
  - On handshake (o_valid & i_ready) with o_addr!=end_ptr: capture the next word the same way as FETCH (o_data<=i_rf_data, o_addr<=rd_ptr, rd_ptr++) and stay in SEND. This sustains 1 word/cycle.
  - On handshake with o_addr==end_ptr: o_valid<=0, o_done<=1 for one cycle, then IDLE.
- o_last = o_valid & (o_addr==end_ptr), combinational.
- Latency: start accepted at edge N, FETCH during cycle N, first o_valid visible after edge N+1.
- Range rules:
  - Word count = ((last-first) mod 16)+1.
  - first==last gives exactly 1 word.
  - first>last wraps, e.g. E,F,0,1.
  - first=0, last=F gives all 16 words.
- i_start while o_busy=1 is ignored; the latched range is unchanged.
- i_abort in FETCH or SEND: next edge gives IDLE, o_valid=0, no o_done pulse. An in-flight word is dropped even if i_ready=1 in the same cycle. i_abort in IDLE has no effect. i_abort has priority over a handshake.
- Snapshot semantics:
  - A word is sampled at its capture edge.
  - Later regfile writes do not alter o_data.
  - A write to the same address at the capture edge yields the pre-write value, because the regfile writes at the edge and reads combinationally.
- i_start and i_abort asserted together in IDLE: the start is accepted.

Decomposition:
- Shared package z16_pkg holds:
  - Z16_DATA_WIDTH=16, Z16_REG_ADDR_WIDTH=4, Z16_NUM_REGS=16.
  - State encoding enum: IDLE=2'd0, FETCH=2'd1, SEND=2'd2.
- No sub-module; the FSM and the two pointers are one flat module.
- The bench instantiates the existing Z16 register file as the read target.

Test Plan:
1. Preload R3=1111, R4=2222, R5=3333 via rd port; start first=3 last=5, i_ready=1 -> (3,1111),(4,2222),(5,3333) on consecutive cycles; o_last only on addr 5; o_done one cycle later; o_busy falls.
2. Preload RA=5555; start first=A last=A -> single word (A,5555) with o_last=1; then o_done.
3. Wrap: start first=E last=1 -> addresses E,F,0,1 in order; exactly 4 handshakes.
4. Backpressure: same as case 1 with i_ready low for 3 cycles on the second word -> o_data=2222 and o_addr=4 held stable; no word skipped or duplicated.
5. Abort: start 0..F, assert i_abort after the 2nd handshake -> o_valid=0 next cycle, no o_done, IDLE; a new start 0..0 then works normally.
6. Snapshot: write R7=AAAA, then during a dump of R7 write R7=BBBB in the cycle after capture -> streamed value AAAA. Also: i_start while busy is ignored, and i_rst mid-dump gives all outputs 0.
